// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// matrix_pkg : shared widths and reader FSM encoding for the matrix memory path
// Revision   : 1.0
// ============================================================================
package matrix_pkg;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;
   localparam int NUM_BANKS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } rd_state_e;
endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : shift-register FIFO whose head entry is a register (registered rdata)
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 4
) (
   input  logic                       clock_i,
   input  logic                       reset_n_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop, do_push;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pop shifts first, so a simultaneous push lands at the post-pop tail.
   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      if (do_pop) begin
         for (int i = 0; i < DEPTH-1; i++) data_d[i] = data_q[i+1];
         count_d = count_q - CNT_W'(1);
      end
      if (do_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == count_d) data_d[i] = wdata_i;
         end
         count_d = count_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   assign rdata_o = data_q[0];
   assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/matrix_bank_reader.sv
`default_nettype none
// ============================================================================
// matrix_bank_reader : credit-based read sequencer streaming four-bank words
// Revision           : 1.0
// ============================================================================
module matrix_bank_reader
   import matrix_pkg::*;
#(
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [ADDR_W:0]             length,
   output logic                        busy,
   output logic                        done,
   output logic [ADDR_W-1:0]           mem_address,
   output logic [NUM_BANKS-1:0]        mem_wren,
   input  logic [NUM_BANKS*DATA_W-1:0] mem_q,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_BANKS*DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0]           out_addr
);
   localparam int WORD_W = NUM_BANKS*DATA_W + ADDR_W;
   localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
   localparam int CRED_W = $clog2(FIFO_DEPTH+RD_LAT+2);
   localparam int REM_W  = ADDR_W + 1;

   if (FIFO_DEPTH < RD_LAT+1) begin : g_depth_check
      $error("matrix_bank_reader: FIFO_DEPTH must be >= RD_LAT+1");
   end

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REM_W-1:0]  remain_q, remain_d;
   logic [RD_LAT-1:0] pipe_vld_q;
   logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
   logic              issue, pop, fifo_full, fifo_empty, credit_ok;
   logic [FCNT_W-1:0] fifo_count;
   logic [CRED_W-1:0] inflight, used, limit;
   logic [WORD_W-1:0] fifo_rdata;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + CRED_W'(pipe_vld_q[i]);
   end

   // A pop this cycle frees a slot before any new issue can land in the FIFO.
   assign pop       = out_valid && out_ready;
   assign used      = CRED_W'(fifo_count) + inflight;
   assign limit     = CRED_W'(FIFO_DEPTH) + CRED_W'(pop);
   assign credit_ok = (used < limit);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      issue    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               remain_d = length;
               state_d  = (length == '0) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (credit_ok) begin
               issue    = 1'b1;
               addr_d   = addr_q + ADDR_W'(1);
               remain_d = remain_q - REM_W'(1);
               if (remain_q == REM_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (inflight == '0 && (fifo_empty || (fifo_count == FCNT_W'(1) && pop)))
               state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         pipe_vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         remain_q       <= remain_d;
         pipe_vld_q[0]  <= issue;
         pipe_addr_q[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
         end
      end
   end

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .push_i    (pipe_vld_q[RD_LAT-1]),
      .wdata_i   ({mem_q, pipe_addr_q[RD_LAT-1]}),
      .pop_i     (pop),
      .rdata_o   (fifo_rdata),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(pipe_vld_q[RD_LAT-1] && fifo_full && !pop));

   assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done        = (state_q == ST_FIN);
   assign mem_address = addr_q;
   assign mem_wren    = '0;
   assign out_valid   = !fifo_empty;
   assign out_data    = fifo_rdata[WORD_W-1:ADDR_W];
   assign out_addr    = fifo_rdata[ADDR_W-1:0];
endmodule
`default_nettype wire

// File: tb/tb_matrix_bank_reader.sv
`default_nettype none
// Bench for matrix_bank_reader: inline two-cycle-latency four-bank memory model and
// an in-order scoreboard of expected {data, addr} words.
module tb_matrix_bank_reader;
   import matrix_pkg::*;
   localparam int LANES_W = NUM_BANKS*DATA_W;
   localparam int WORD_W  = LANES_W + ADDR_W;

   logic               clock     = 1'b0;
   logic               reset_n   = 1'b0;
   logic               start     = 1'b0;
   logic [ADDR_W-1:0]  base_addr = '0;
   logic [ADDR_W:0]    length    = '0;
   logic               out_ready = 1'b0;
   logic               busy, done, out_valid;
   logic [ADDR_W-1:0]  mem_address, out_addr;
   logic [NUM_BANKS-1:0] mem_wren;
   logic [LANES_W-1:0] mem_q, out_data;

   logic [LANES_W-1:0] mem [256];
   logic [ADDR_W-1:0]  mem_addr_r = '0;
   logic [LANES_W-1:0] mem_q_r    = '0;

   int checks = 0, failures = 0, cyc = 0;
   int hs_count = 0, first_hs = -1, last_hs = -1;
   logic [WORD_W-1:0] sb [$];

   matrix_bank_reader dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .mem_address (mem_address),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_addr    (out_addr)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Memory: registered address, registered output.
   always @(posedge clock) begin
      mem_addr_r <= mem_address;
      mem_q_r    <= mem[mem_addr_r];
   end
   assign mem_q = mem_q_r;

   function automatic logic [WORD_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      w = DATA_W'(a);
      return {w + 16'd4, w + 16'd3, w + 16'd2, w + 16'd1, a};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: handshakes pop the scoreboard; stalled outputs must hold.
   initial begin : mon
      logic [WORD_W-1:0] e;
      bit                prev_stall;
      logic [LANES_W-1:0] prev_data;
      logic [ADDR_W-1:0]  prev_addr;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_addr  = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            prev_stall = 1'b0;
         end else begin
            chk("fifo_bound", 64'(int'(dut.fifo_count) <= 4), 64'd1);
            if (prev_stall) begin
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_data", out_data, prev_data);
               chk("stall_addr", 64'(out_addr), 64'(prev_addr));
            end
            if (out_valid && out_ready) begin
               chk("word_expected", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("out_data", out_data, e[WORD_W-1:ADDR_W]);
                  chk("out_addr", 64'(out_addr), 64'(e[ADDR_W-1:0]));
               end
               hs_count++;
               last_hs = cyc;
               if (first_hs < 0) first_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
         end
      end
   end

   // mode 0: out_ready always high; mode 1: one cycle high, three low.
   task automatic run_txn(input logic [ADDR_W-1:0] b, input int len, input int mode,
                          input bit timing, input bit dbl);
      int  c0, ndone, nhs0;
      bit  fin;
      for (int i = 0; i < len; i++) sb.push_back(exp_word(8'(int'(b) + i)));
      nhs0      = hs_count;
      first_hs  = -1;
      base_addr = b;
      length    = 9'(len);
      start     = 1'b1;
      out_ready = (mode == 0);
      tick();
      start = 1'b0;
      c0    = cyc;
      if (len == 0) begin
         chk("len0_done", 64'(done), 64'd1);
         chk("len0_busy", 64'(busy), 64'd0);
         chk("len0_valid", 64'(out_valid), 64'd0);
         tick();
         chk("len0_done_clear", 64'(done), 64'd0);
         chk("len0_valid2", 64'(out_valid), 64'd0);
      end else begin
         chk("busy_after_start", 64'(busy), 64'd1);
         ndone = 0;
         fin   = 1'b0;
         for (int k = 0; k < 4000 && !fin; k++) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 4) == 3);
            if (dbl && k == 2) begin
               start     = 1'b1;
               base_addr = 8'd200;
               length    = 9'd3;
            end else begin
               start = 1'b0;
            end
            tick();
            if (done) begin
               fin = 1'b1;
               ndone++;
               chk("done_after_last_hs", 64'(last_hs), 64'(cyc - 1));
               chk("busy_at_done", 64'(busy), 64'd0);
            end
         end
         start = 1'b0;
         chk("done_seen", 64'(fin), 64'd1);
         if (timing) begin
            chk("first_latency", 64'(first_hs), 64'(c0 + 3));
            chk("back_to_back", 64'(last_hs), 64'(c0 + len + 2));
         end
         for (int t = 0; t < 6; t++) begin
            out_ready = 1'b1;
            tick();
            if (done) ndone++;
         end
         chk("done_pulses", 64'(ndone), 64'd1);
         chk("sb_empty", 64'(sb.size()), 64'd0);
         chk("word_count", 64'(hs_count - nhs0), 64'(len));
         chk("idle_busy", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++)
         mem[a] = {DATA_W'(a + 4), DATA_W'(a + 3), DATA_W'(a + 2), DATA_W'(a + 1)};
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mem_address", 64'(mem_address), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("mem_wren", 64'(mem_wren), 64'd0);
      reset_n = 1'b1;
      tick();

      run_txn(8'd4,   4,   0, 1'b1, 1'b0);
      run_txn(8'd254, 4,   0, 1'b1, 1'b0);
      run_txn(8'd20,  16,  1, 1'b0, 1'b0);
      run_txn(8'd9,   0,   0, 1'b0, 1'b0);
      run_txn(8'd37,  256, 0, 1'b1, 1'b0);

      // Reset while words sit in the FIFO during DRAIN.
      for (int i = 0; i < 3; i++) sb.push_back(exp_word(8'(50 + i)));
      base_addr = 8'd50;
      length    = 9'd3;
      out_ready = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20 && dut.state_q != ST_DRAIN; k++) tick();
      chk("reach_drain", 64'(dut.state_q == ST_DRAIN), 64'd1);
      repeat (3) tick();
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      chk("pre_reset_addr", 64'(out_addr), 64'd50);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_mem_address", 64'(mem_address), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_data", out_data, 64'd0);
      chk("mid_rst_out_addr", 64'(out_addr), 64'd0);
      sb.delete();
      tick();
      tick();
      reset_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("no_done_after_reset", 64'(done), 64'd0);
         chk("no_valid_after_reset", 64'(out_valid), 64'd0);
      end

      run_txn(8'd10,  5, 0, 1'b1, 1'b0);
      run_txn(8'd100, 6, 0, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
